// File: rtl/codes.sv
// rtl/codes.sv - shared bus-arbiter state type, word byte-enable constant and endian swap helper
package codes;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUS_FETCH = 2'd1,
        BUS_DATA  = 2'd2,
        RESP      = 2'd3
    } bus_state_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    // Bus lanes are little-endian, CPU words big-endian: reverse the four bytes.
    function automatic logic [31:0] swap_endian(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one Avalon-MM master between instruction fetch and data access
module mem_bus_arbiter
    import codes::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_done_o,
    output logic [31:0] fetch_data_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_be_i,
    output logic        data_done_o,
    output logic [31:0] data_rdata_o,

    output logic        stall_o,
    output logic        timeout_o,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

    bus_state_t  state, state_d;
    logic        hold_we, hold_we_d;
    logic [31:0] wait_cnt, wait_cnt_d;

    logic [31:0] address_d;
    logic        read_d, write_d;
    logic [31:0] writedata_d;
    logic [3:0]  byteenable_d;
    logic        fetch_done_d, data_done_d;
    logic [31:0] fetch_data_d, data_rdata_d;
    logic        timeout_d;
    logic        bus_active;

    // Word addressing only; the low address bits never reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr_i[1:0], data_addr_i[1:0]};

    assign bus_active = (state == BUS_FETCH) || (state == BUS_DATA);
    assign stall_o    = (fetch_req_i | data_req_i) & ~(fetch_done_o | data_done_o);

    always_comb begin
        state_d      = state;
        hold_we_d    = hold_we;
        wait_cnt_d   = wait_cnt;
        address_d    = address;
        read_d       = read;
        write_d      = write;
        writedata_d  = writedata;
        byteenable_d = byteenable;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        fetch_data_d = fetch_data_o;
        data_rdata_d = data_rdata_o;
        timeout_d    = timeout_o;

        case (state)
            IDLE: begin
                if (data_req_i) begin
                    state_d      = BUS_DATA;
                    hold_we_d    = data_we_i;
                    address_d    = {data_addr_i[31:2], 2'b00};
                    read_d       = ~data_we_i;
                    write_d      = data_we_i;
                    writedata_d  = swap_endian(data_wdata_i);
                    byteenable_d = data_be_i;
                end else if (fetch_req_i) begin
                    state_d      = BUS_FETCH;
                    hold_we_d    = 1'b0;
                    address_d    = {fetch_addr_i[31:2], 2'b00};
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    byteenable_d = BYTEEN_WORD;
                end
            end
            BUS_FETCH: begin
                if (!waitrequest) begin
                    state_d      = RESP;
                    read_d       = 1'b0;
                    fetch_done_d = 1'b1;
                    fetch_data_d = swap_endian(readdata);
                end
            end
            BUS_DATA: begin
                if (!waitrequest) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    data_done_d = 1'b1;
                    if (!hold_we) begin
                        data_rdata_d = swap_endian(readdata);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        // Saturating stall counter; the flag is sticky so saturation never matters.
        if (bus_active && waitrequest) begin
            if (wait_cnt != 32'hFFFF_FFFF) begin
                wait_cnt_d = wait_cnt + 32'd1;
            end
        end else begin
            wait_cnt_d = 32'd0;
        end

        if ((TIMEOUT_CYCLES != 0) && (wait_cnt_d == TIMEOUT_LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_we      <= 1'b0;
            wait_cnt     <= 32'd0;
            address      <= 32'd0;
            read         <= 1'b0;
            write        <= 1'b0;
            writedata    <= 32'd0;
            byteenable   <= 4'd0;
            fetch_done_o <= 1'b0;
            data_done_o  <= 1'b0;
            fetch_data_o <= 32'd0;
            data_rdata_o <= 32'd0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_d;
            hold_we      <= hold_we_d;
            wait_cnt     <= wait_cnt_d;
            address      <= address_d;
            read         <= read_d;
            write        <= write_d;
            writedata    <= writedata_d;
            byteenable   <= byteenable_d;
            fetch_done_o <= fetch_done_d;
            data_done_o  <= data_done_d;
            fetch_data_o <= fetch_data_d;
            data_rdata_o <= data_rdata_d;
            timeout_o    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter against a timeline model
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req_i = 1'b0;
    logic [31:0] fetch_addr_i = 32'd0;
    logic        fetch_done_o;
    logic [31:0] fetch_data_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = 32'd0;
    logic [31:0] data_wdata_i = 32'd0;
    logic [3:0]  data_be_i = 4'd0;
    logic        data_done_o;
    logic [31:0] data_rdata_o;
    logic        stall_o;
    logic        timeout_o;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'd0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_done_o(fetch_done_o), .fetch_data_o(fetch_data_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
        .data_done_o(data_done_o), .data_rdata_o(data_rdata_o),
        .stall_o(stall_o), .timeout_o(timeout_o),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected architectural state kept by the bench.
    logic [31:0] m_fdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    bit          m_tmo = 1'b0;

    // Memory responder: each new strobe takes its wait count and read word from the queues.
    int          resp_waits[$];
    logic [31:0] resp_words[$];
    int          strobe_age = 0;
    int          cur_budget = 0;

    always @(negedge clk) begin
        if (reset || !(read || write)) begin
            strobe_age  = 0;
            waitrequest = 1'b0;
        end else begin
            if (strobe_age == 0) begin
                if (resp_waits.size() > 0) begin
                    cur_budget = resp_waits.pop_front();
                    readdata   = resp_words.pop_front();
                end else begin
                    cur_budget = 0;
                    readdata   = 32'hDEAD_BEEF;
                end
            end
            strobe_age++;
            waitrequest = (strobe_age <= cur_budget);
        end
    end

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_fdata = 32'd0;
        m_rdata = 32'd0;
        m_tmo   = 1'b0;
    endtask

    // Timeline model: data (if any) strobes on cycle 1 for wdd+1 cycles and is done the cycle
    // after; fetch strobes two cycles after data's done (RESP then IDLE), or on cycle 1 alone.
    task automatic run_case(input bit f, input bit d, input bit we,
                            input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                            input logic [3:0] be, input int wf, input int wdd,
                            input logic [31:0] rf, input logic [31:0] rdd, input string tag);
        int d_s, d_e, d_done, f_s, f_e, f_done, last, tmo_at;
        bit in_d, in_f, e_read, e_write, e_stall, e_tmo;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        resp_waits.delete();
        resp_words.delete();
        if (d) begin resp_waits.push_back(wdd); resp_words.push_back(rdd); end
        if (f) begin resp_waits.push_back(wf);  resp_words.push_back(rf);  end
        d_s = 1; d_e = 1 + wdd; d_done = d ? d_e + 1 : -1;
        f_s = d ? d_done + 2 : 1; f_e = f_s + wf; f_done = f ? f_e + 1 : -1;
        last = (d_done > f_done) ? d_done : f_done;
        tmo_at = 1 << 30;
        if (f && wf >= 4) tmo_at = f_s + 4;
        if (d && wdd >= 4) tmo_at = d_s + 4;
        if (m_tmo) tmo_at = 0;
        fetch_addr_i = fa; data_addr_i = da; data_wdata_i = wd; data_be_i = be; data_we_i = we;
        for (int c = 0; c <= last; c++) begin
            fetch_req_i = f && (c <= f_done);
            data_req_i  = d && (c <= d_done);
            @(negedge clk);
            in_d = d && c >= d_s && c <= d_e;
            in_f = f && c >= f_s && c <= f_e;
            e_read  = (in_d && !we) || in_f;
            e_write = in_d && we;
            e_addr  = in_d ? {da[31:2], 2'b00} : {fa[31:2], 2'b00};
            e_be    = in_d ? be : 4'b1111;
            if (c == f_done) m_fdata = bswap(rf);
            if (c == d_done && !we) m_rdata = bswap(rdd);
            e_stall = (fetch_req_i || data_req_i) && !(c == f_done || c == d_done);
            e_tmo   = m_tmo || (c >= tmo_at);
            checks++;
            if (read !== e_read || write !== e_write) begin
                errors++;
                $display("FAIL %s strobe c%0d: read,write=%b%b expected %b%b", tag, c, read, write, e_read, e_write);
            end
            if (in_d || in_f) begin
                checks++;
                if (address !== e_addr || byteenable !== e_be) begin
                    errors++;
                    $display("FAIL %s addr c%0d: %h/%b expected %h/%b", tag, c, address, byteenable, e_addr, e_be);
                end
            end
            if (in_d && we) begin
                checks++;
                if (writedata !== bswap(wd)) begin
                    errors++;
                    $display("FAIL %s writedata c%0d: %h expected %h", tag, c, writedata, bswap(wd));
                end
            end
            checks++;
            if (fetch_done_o !== (c == f_done) || data_done_o !== (c == d_done)) begin
                errors++;
                $display("FAIL %s done c%0d: fetch,data=%b%b expected %b%b", tag, c,
                         fetch_done_o, data_done_o, (c == f_done), (c == d_done));
            end
            checks++;
            if (stall_o !== e_stall) begin
                errors++;
                $display("FAIL %s stall c%0d: %b expected %b", tag, c, stall_o, e_stall);
            end
            checks++;
            if (timeout_o !== e_tmo) begin
                errors++;
                $display("FAIL %s timeout c%0d: %b expected %b", tag, c, timeout_o, e_tmo);
            end
            checks++;
            if (fetch_data_o !== m_fdata || data_rdata_o !== m_rdata) begin
                errors++;
                $display("FAIL %s rdata c%0d: %h/%h expected %h/%h", tag, c, fetch_data_o, data_rdata_o, m_fdata, m_rdata);
            end
            @(posedge clk);
            #1;
        end
        m_tmo = m_tmo || (tmo_at <= last);
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({read, write, fetch_done_o, data_done_o, timeout_o, stall_o} !== 6'b0 ||
            address !== 32'd0 || writedata !== 32'd0 || byteenable !== 4'd0 ||
            fetch_data_o !== 32'd0 || data_rdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: r%b w%b a%h wd%h be%b fd%h dr%h expected all zero",
                     read, write, address, writedata, byteenable, fetch_data_o, data_rdata_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        run_case(1, 0, 0, 32'hBFC0_0000, 32'd0, 32'd0, 4'd0, 0, 0, 32'h7856_3412, 32'd0, "fetch");
        checks++;
        if (fetch_data_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_word: %h expected 12345678", fetch_data_o);
        end
    endtask

    task automatic test_store_wait();
        run_case(0, 1, 1, 32'd0, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011, 0, 3, 32'd0, 32'h1111_2222, "store_wait");
    endtask

    task automatic test_back_to_back();
        run_case(1, 1, 0, 32'h0040_0010, 32'h0000_2000, 32'd0, 4'b1111, 0, 0,
                 32'h0102_0304, 32'hA1B2_C3D4, "fetch_and_load");
    endtask

    task automatic test_unaligned();
        run_case(0, 1, 0, 32'd0, 32'h0000_1007, 32'd0, 4'b1000, 0, 1, 32'd0, 32'hCAFE_F00D, "unaligned");
    endtask

    task automatic test_timeout();
        run_case(1, 0, 0, 32'h0000_0100, 32'd0, 32'd0, 4'd0, 6, 0, 32'h5555_AAAA, 32'd0, "timeout");
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: %b expected 1", timeout_o);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: %b expected 0", timeout_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        resp_waits.delete();
        resp_words.delete();
        resp_waits.push_back(5);
        resp_words.push_back(32'h0BAD_0BAD);
        fetch_addr_i = 32'h0000_0040;
        fetch_req_i  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read !== 1'b1 || waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: read=%b wait=%b expected 1 1", read, waitrequest);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        fetch_req_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_fdata = 32'd0; m_rdata = 32'd0; m_tmo = 1'b0;
        @(negedge clk);
        checks++;
        if ({read, write, fetch_done_o, data_done_o, timeout_o} !== 5'b0 || address !== 32'd0 ||
            byteenable !== 4'd0 || fetch_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: r%b w%b a%h be%b fd%h expected zeros", read, write, address, byteenable, fetch_data_o);
        end
        @(posedge clk);
        #1;
        run_case(1, 0, 0, 32'h0000_0044, 32'd0, 32'd0, 4'd0, 1, 0, 32'hFEED_BEEF, 32'd0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit f, d;
            int sel;
            sel = $urandom_range(0, 2);
            f = (sel != 1);
            d = (sel != 0);
            run_case(f, d, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom, "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_back_to_back();
        test_unaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
